// File: rtl/mano_dr_seq_unit_pkg.sv
// Shared constants for the Mano basic-computer control slice:
// opcode numbers, T-step indices and the default DR load mask.
package mano_pkg;

    // Memory-reference opcodes (IR[14:12]); 7 selects register/IO.
    localparam logic [2:0] OPC_AND    = 3'd0;
    localparam logic [2:0] OPC_ADD    = 3'd1;
    localparam logic [2:0] OPC_LDA    = 3'd2;
    localparam logic [2:0] OPC_STA    = 3'd3;
    localparam logic [2:0] OPC_BUN    = 3'd4;
    localparam logic [2:0] OPC_BSA    = 3'd5;
    localparam logic [2:0] OPC_ISZ    = 3'd6;
    localparam logic [2:0] OPC_REG_IO = 3'd7;

    // Timing-step indices into t_out.
    localparam int T_FETCH0 = 0;
    localparam int T_FETCH1 = 1;
    localparam int T_DECODE = 2;
    localparam int T_EXEC3  = 3;
    localparam int T_EXEC4  = 4;
    localparam int T_EXEC5  = 5;

    // AND, ADD, LDA and ISZ bring the memory operand into DR at T4.
    localparam logic [7:0] LD_MASK_DFLT = 8'b0100_0111;

    // One-hot decode of an opcode into D0..D7.
    function automatic logic [7:0] opc_decode(input logic [2:0] opc);
        logic [7:0] d;
        d      = '0;
        d[opc] = 1'b1;
        return d;
    endfunction

endpackage

// File: rtl/mano_dr_seq_unit_if.sv
// Control/bus bundle between the control unit (master) and the DR
// sequencing unit (slave).
interface mano_dr_seq_unit_if #(
    parameter int WIDTH   = 16,
    parameter int SC_BITS = 4
);
    localparam int NUM_T = 2 ** SC_BITS;

    logic             run;
    logic             sc_clr;
    logic [2:0]       opcode;
    logic             dr_clr;
    logic [WIDTH-1:0] bus_in;
    logic [NUM_T-1:0] t_out;
    logic [7:0]       d_out;
    logic             dr_ld;
    logic             dr_inc;
    logic [WIDTH-1:0] dr_q;
    logic             dr_zero;

    modport master (
        output run, sc_clr, opcode, dr_clr, bus_in,
        input  t_out, d_out, dr_ld, dr_inc, dr_q, dr_zero
    );

    modport slave (
        input  run, sc_clr, opcode, dr_clr, bus_in,
        output t_out, d_out, dr_ld, dr_inc, dr_q, dr_zero
    );
endinterface

// File: rtl/mano_dr_seq_unit_seq_counter.sv
// Instruction sequence counter SC with one-hot T-signal decode.
module mano_seq_counter #(
    parameter int SC_BITS = 4,
    localparam int NUM_T  = 2 ** SC_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             sc_clr,
    output logic [NUM_T-1:0] t_out
);

    logic [SC_BITS-1:0] sc;

    // SC: reset, then end-of-instruction clear, then advance while running.
    // Wrap from NUM_T-1 back to 0 is the natural modulo roll-over.
    always_ff @(posedge clk) begin
        if (rst)
            sc <= '0;
        else if (sc_clr)
            sc <= '0;
        else if (run)
            sc <= sc + 1'b1;
    end

    // One-hot decode: exactly one T bit is set at all times.
    always_comb begin
        t_out     = '0;
        t_out[sc] = 1'b1;
    end

endmodule

// File: rtl/mano_dr_seq_unit.sv
// DR unit: sequence counter, opcode decode and the data register with
// load (T4, masked by opcode), ISZ increment (T5) and clear.
module mano_dr_seq_unit
    import mano_pkg::*;
#(
    parameter int         WIDTH   = 16,
    parameter int         SC_BITS = 4,
    parameter logic [7:0] LD_MASK = LD_MASK_DFLT,
    parameter int         INC_OPC = int'(OPC_ISZ)
) (
    input  logic                clk,
    input  logic                rst,
    mano_dr_seq_unit_if.slave   dr_if
);

    localparam int NUM_T = 2 ** SC_BITS;

    logic [NUM_T-1:0] t_vec;
    logic [7:0]       d_vec;
    logic             ld;
    logic             inc;
    logic [WIDTH-1:0] dr;

    mano_seq_counter #(
        .SC_BITS (SC_BITS)
    ) u_sc (
        .clk    (clk),
        .rst    (rst),
        .run    (dr_if.run),
        .sc_clr (dr_if.sc_clr),
        .t_out  (t_vec)
    );

    // Opcode decode and DR control strobes; run gates both so a halted
    // machine never disturbs DR except through an explicit clear.
    always_comb begin
        d_vec = opc_decode(dr_if.opcode);
        ld    = dr_if.run & t_vec[T_EXEC4] & (|(d_vec & LD_MASK));
        inc   = dr_if.run & t_vec[T_EXEC5] & d_vec[INC_OPC];
    end

    // DR: clear beats load, load beats increment (covers any mask/INC_OPC
    // overlap), increment wraps modulo 2**WIDTH.
    always_ff @(posedge clk) begin
        if (rst)
            dr <= '0;
        else if (dr_if.dr_clr)
            dr <= '0;
        else if (ld)
            dr <= dr_if.bus_in;
        else if (inc)
            dr <= dr + 1'b1;
    end

    assign dr_if.t_out   = t_vec;
    assign dr_if.d_out   = d_vec;
    assign dr_if.dr_ld   = ld;
    assign dr_if.dr_inc  = inc;
    assign dr_if.dr_q    = dr;
    assign dr_if.dr_zero = (dr == '0);

endmodule
